// File: rtl/aquila_pkg.sv
// rtl/aquila_pkg.sv - shared types for the Aquila data-side memory-map router
package aquila_pkg;

    // Decoded destination of a core data access
    typedef enum logic [1:0] {
        RGN_DCACHE,
        RGN_DEV,
        RGN_CLINT,
        RGN_NONE
    } region_e;

    // Top address nibble of each region
    localparam logic [3:0] NIB_DCACHE_LO = 4'h8;
    localparam logic [3:0] NIB_DCACHE_HI = 4'hB;
    localparam logic [3:0] NIB_DEV       = 4'hC;
    localparam logic [3:0] NIB_CLINT     = 4'hF;

    // Router request FSM
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_e;

endpackage

// File: rtl/aquila_addr_decode.sv
// rtl/aquila_addr_decode.sv - combinational address to region/device-index decoder
module aquila_addr_decode
    import aquila_pkg::*;
#(
    parameter int NUM_DEV = 4
) (
    input  logic [7:0] addr_hi_i,
    output region_e    region_o,
    output logic [3:0] dev_idx_o
);

    // Top nibble selects the region; the next nibble selects the device window
    always_comb begin
        region_o  = RGN_NONE;
        dev_idx_o = addr_hi_i[3:0];
        if (addr_hi_i[7:4] >= NIB_DCACHE_LO && addr_hi_i[7:4] <= NIB_DCACHE_HI) begin
            region_o = RGN_DCACHE;
        end else if (addr_hi_i[7:4] == NIB_DEV) begin
            if (32'(addr_hi_i[3:0]) < NUM_DEV) begin
                region_o = RGN_DEV;
            end
        end else if (addr_hi_i[7:4] == NIB_CLINT) begin
            region_o = RGN_CLINT;
        end
    end

endmodule

// File: rtl/aquila_dmem_router.sv
// rtl/aquila_dmem_router.sv - registered data-side router to D-cache, CLINT and devices
module aquila_dmem_router
    import aquila_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_DEV        = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          p_strobe,
    input  logic [ADDR_WIDTH-1:0]         p_addr,
    input  logic                          p_rw,
    input  logic [DATA_WIDTH/8-1:0]       p_byte_enable,
    input  logic [DATA_WIDTH-1:0]         p_wdata,
    output logic [DATA_WIDTH-1:0]         p_rdata,
    output logic                          p_ready,
    output logic                          p_err,
    output logic                          dc_strobe,
    output logic                          dc_rw,
    input  logic                          dc_ready,
    input  logic [DATA_WIDTH-1:0]         dc_rdata,
    output logic [NUM_DEV-1:0]            dev_strobe,
    output logic                          dev_rw,
    input  logic [NUM_DEV-1:0]            dev_ready,
    input  logic [NUM_DEV*DATA_WIDTH-1:0] dev_rdata,
    output logic                          clint_en,
    output logic                          clint_we,
    input  logic [DATA_WIDTH-1:0]         clint_rdata,
    output logic [ADDR_WIDTH-1:0]         t_addr,
    output logic [DATA_WIDTH/8-1:0]       t_be,
    output logic [DATA_WIDTH-1:0]         t_wdata
);

    localparam int CW = $clog2(TIMEOUT_CYCLES) + 1;

    state_e                  state_q, state_d;
    region_e                 rgn_q, rgn_dec;
    logic [3:0]              dev_idx_q, dev_idx_dec;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    rw_q;
    logic [DATA_WIDTH/8-1:0] be_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [CW-1:0]           cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    err_q, err_d;
    logic                    latch_en;
    logic                    sel_ready;
    logic [DATA_WIDTH-1:0]   sel_rdata;
    logic                    issue;

    aquila_addr_decode #(
        .NUM_DEV (NUM_DEV)
    ) u_decode (
        .addr_hi_i (p_addr[ADDR_WIDTH-1 -: 8]),
        .region_o  (rgn_dec),
        .dev_idx_o (dev_idx_dec)
    );

    assign latch_en = (state_q == ST_IDLE) && p_strobe;
    assign issue    = (state_q == ST_ISSUE);

    // Ready/data of the latched target only; everything else is ignored
    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = '0;
        case (rgn_q)
            RGN_DCACHE: begin
                sel_ready = dc_ready;
                sel_rdata = dc_rdata;
            end
            RGN_DEV: begin
                for (int k = 0; k < NUM_DEV; k++) begin
                    if (32'(dev_idx_q) == k) begin
                        sel_ready = dev_ready[k];
                        sel_rdata = dev_rdata[k*DATA_WIDTH +: DATA_WIDTH];
                    end
                end
            end
            default: begin
                sel_ready = 1'b0;
                sel_rdata = '0;
            end
        endcase
    end

    // Next state, response capture and timeout counting
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (p_strobe) begin
                    if (rgn_dec == RGN_NONE) begin
                        state_d = ST_RESP;
                        rdata_d = '0;
                        err_d   = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                        cnt_d   = '0;
                    end
                end
            end
            ST_ISSUE: begin
                if (rgn_q == RGN_CLINT) begin
                    state_d = ST_RESP;
                    rdata_d = rw_q ? '0 : clint_rdata;
                    err_d   = 1'b0;
                end else if (sel_ready) begin
                    state_d = ST_RESP;
                    rdata_d = rw_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (sel_ready) begin
                    state_d = ST_RESP;
                    rdata_d = rw_q ? '0 : sel_rdata;
                    err_d   = 1'b0;
                end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
                    state_d = ST_RESP;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM, counter and response registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request latches, loaded only when a request is accepted in IDLE
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rgn_q     <= RGN_DCACHE;
            dev_idx_q <= '0;
            addr_q    <= '0;
            rw_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
        end else if (latch_en) begin
            rgn_q     <= rgn_dec;
            dev_idx_q <= dev_idx_dec;
            addr_q    <= p_addr;
            rw_q      <= p_rw;
            be_q      <= p_byte_enable;
            wdata_q   <= p_wdata;
        end
    end

    // One-cycle target strobes in ISSUE, write flags qualified by the strobe
    always_comb begin
        dev_strobe = '0;
        for (int k = 0; k < NUM_DEV; k++) begin
            dev_strobe[k] = issue && (rgn_q == RGN_DEV) && (32'(dev_idx_q) == k);
        end
    end

    assign dc_strobe = issue && (rgn_q == RGN_DCACHE);
    assign clint_en  = issue && (rgn_q == RGN_CLINT);
    assign dc_rw     = dc_strobe && rw_q;
    assign dev_rw    = (|dev_strobe) && rw_q;
    assign clint_we  = clint_en && rw_q;

    assign t_addr  = addr_q;
    assign t_be    = be_q;
    assign t_wdata = wdata_q;

    assign p_ready = (state_q == ST_RESP);
    assign p_err   = p_ready && err_q;
    assign p_rdata = rdata_q;

endmodule

// File: tb/tb_aquila_dmem_router.sv
// tb/tb_aquila_dmem_router.sv - self-checking bench for aquila_dmem_router
module tb_aquila_dmem_router;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int ND = 4;
    localparam int TO = 16;

    logic           clk, rst;
    logic           p_strobe, p_rw;
    logic [AW-1:0]  p_addr;
    logic [3:0]     p_byte_enable;
    logic [DW-1:0]  p_wdata, p_rdata;
    logic           p_ready, p_err;
    logic           dc_strobe, dc_rw, dc_ready;
    logic [DW-1:0]  dc_rdata;
    logic [ND-1:0]  dev_strobe, dev_ready;
    logic           dev_rw;
    logic [ND*DW-1:0] dev_rdata;
    logic           clint_en, clint_we;
    logic [DW-1:0]  clint_rdata;
    logic [AW-1:0]  t_addr;
    logic [3:0]     t_be;
    logic [DW-1:0]  t_wdata;

    aquila_dmem_router #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_DEV(ND), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .p_strobe(p_strobe), .p_addr(p_addr), .p_rw(p_rw),
        .p_byte_enable(p_byte_enable), .p_wdata(p_wdata),
        .p_rdata(p_rdata), .p_ready(p_ready), .p_err(p_err),
        .dc_strobe(dc_strobe), .dc_rw(dc_rw), .dc_ready(dc_ready), .dc_rdata(dc_rdata),
        .dev_strobe(dev_strobe), .dev_rw(dev_rw), .dev_ready(dev_ready), .dev_rdata(dev_rdata),
        .clint_en(clint_en), .clint_we(clint_we), .clint_rdata(clint_rdata),
        .t_addr(t_addr), .t_be(t_be), .t_wdata(t_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // tgt: 0 dcache, 1 device, 2 clint, 3 unmapped
    typedef struct {
        int          issue_cyc;
        int          done_cyc;
        int          tgt;
        int          idx;
        logic        rw;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wd;
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t q[$];

    int          last_ready_cyc;
    logic [31:0] last_rdata;
    logic        last_err;
    logic [3:0]  last_dev_strobe;
    logic        last_dev_rw;
    logic [3:0]  last_t_be;
    int          dev_strobe_cycles;

    exp_t        cf;
    logic        e_dc, e_cl;
    logic [3:0]  e_dev;
    bit          at_issue;

    // Compare process: every cycle, strobes and completions against the model queue
    always @(negedge clk) begin
        e_dc = 1'b0; e_cl = 1'b0; e_dev = '0; at_issue = 1'b0;
        if (q.size() > 0) begin
            cf = q[0];
            if (cf.issue_cyc == cyc && cf.tgt != 3) begin
                at_issue = 1'b1;
                if (cf.tgt == 0) e_dc = 1'b1;
                if (cf.tgt == 1) e_dev[cf.idx] = 1'b1;
                if (cf.tgt == 2) e_cl = 1'b1;
            end
        end
        check(dc_strobe == e_dc, "dc_strobe", 64'(dc_strobe), 64'(e_dc));
        check(dev_strobe == e_dev, "dev_strobe", 64'(dev_strobe), 64'(e_dev));
        check(clint_en == e_cl, "clint_en", 64'(clint_en), 64'(e_cl));
        if (at_issue) begin
            check(t_addr == cf.addr, "t_addr", 64'(t_addr), 64'(cf.addr));
            check(t_be == cf.be, "t_be", 64'(t_be), 64'(cf.be));
            check(t_wdata == cf.wd, "t_wdata", 64'(t_wdata), 64'(cf.wd));
            if (cf.tgt == 0) check(dc_rw == cf.rw, "dc_rw", 64'(dc_rw), 64'(cf.rw));
            if (cf.tgt == 1) check(dev_rw == cf.rw, "dev_rw", 64'(dev_rw), 64'(cf.rw));
            if (cf.tgt == 2) check(clint_we == cf.rw, "clint_we", 64'(clint_we), 64'(cf.rw));
        end
        if (|dev_strobe) begin
            dev_strobe_cycles++;
            last_dev_strobe = dev_strobe;
            last_dev_rw     = dev_rw;
            last_t_be       = t_be;
        end
        if (p_ready) begin
            last_ready_cyc = cyc;
            last_rdata     = p_rdata;
            last_err       = p_err;
        end
        if (q.size() > 0 && q[0].done_cyc == cyc) begin
            check(p_ready == 1'b1, "p_ready_timing", 64'(p_ready), 64'd1);
            if (p_ready) begin
                check(p_rdata == q[0].rdata, "p_rdata", 64'(p_rdata), 64'(q[0].rdata));
                check(p_err == q[0].err, "p_err", 64'(p_err), 64'(q[0].err));
            end
            void'(q.pop_front());
        end else begin
            check(p_ready == 1'b0, "p_ready_spurious", 64'(p_ready), 64'd0);
        end
    end

    // Idle cycles with random, meaningless ready activity on every target
    task automatic idle(input int n);
        logic [31:0] r;
        for (int i = 0; i < n; i++) begin
            r = $urandom;
            p_strobe  = 1'b0;
            dev_ready = r[ND-1:0];
            dc_ready  = r[8];
            @(negedge clk);
        end
    endtask

    // One request: model its outcome, then play the target with ready after d cycles
    task automatic txn(input logic [31:0] a, input logic rw, input logic [3:0] be,
                       input logic [31:0] wd, input int d, input logic [31:0] rd,
                       output int t0);
        exp_t        e;
        logic [3:0]  nib;
        logic [3:0]  nz;
        logic [31:0] r;
        nib = a[31:28];
        e.idx = int'(a[27:24]);
        if (nib >= 4'h8 && nib <= 4'hB)           e.tgt = 0;
        else if (nib == 4'hC && e.idx < ND)        e.tgt = 1;
        else if (nib == 4'hF)                      e.tgt = 2;
        else                                       e.tgt = 3;
        if (e.tgt != 1) e.idx = 0;
        t0 = cyc;
        e.issue_cyc = t0 + 1;
        e.rw = rw; e.addr = a; e.be = be; e.wd = wd;
        if (e.tgt == 3) begin
            e.done_cyc = t0 + 1; e.err = 1'b1; e.rdata = '0;
        end else if (e.tgt == 2) begin
            e.done_cyc = t0 + 2; e.err = 1'b0; e.rdata = rw ? 32'h0 : rd;
        end else if (d <= TO) begin
            e.done_cyc = t0 + 2 + d; e.err = 1'b0; e.rdata = rw ? 32'h0 : rd;
        end else begin
            e.done_cyc = t0 + 2 + TO; e.err = 1'b1; e.rdata = '0;
        end
        dc_rdata    = (e.tgt == 0) ? rd : $urandom;
        clint_rdata = (e.tgt == 2) ? rd : $urandom;
        dev_rdata   = {$urandom, $urandom, $urandom, $urandom};
        if (e.tgt == 1) dev_rdata[e.idx*DW +: DW] = rd;
        p_strobe = 1'b1; p_addr = a; p_rw = rw; p_byte_enable = be; p_wdata = wd;
        q.push_back(e);
        @(negedge clk);
        while (cyc <= e.done_cyc) begin
            r  = $urandom;
            nz = r[3:0];
            if (e.tgt == 1) nz[e.idx] = (cyc == t0 + 1 + d);
            dev_ready = nz;
            dc_ready  = (e.tgt == 0) ? (cyc == t0 + 1 + d) : r[8];
            p_strobe  = r[9];
            p_addr    = $urandom;
            p_rw      = r[10];
            @(negedge clk);
        end
        p_strobe  = 1'b0;
        dc_ready  = 1'b0;
        dev_ready = '0;
    endtask

    int          t0;
    int          cat, d, v;
    logic [31:0] a;
    logic        rw;
    exp_t        ew;

    initial begin
        rst = 1'b1;
        p_strobe = 0; p_addr = 0; p_rw = 0; p_byte_enable = 0; p_wdata = 0;
        dc_ready = 0; dc_rdata = 0; dev_ready = 0; dev_rdata = 0; clint_rdata = 0;
        dev_strobe_cycles = 0;
        repeat (3) @(negedge clk);
        check(p_ready == 0, "rst_p_ready", 64'(p_ready), 0);
        check(p_rdata == 0, "rst_p_rdata", 64'(p_rdata), 0);
        check(t_addr == 0, "rst_t_addr", 64'(t_addr), 0);
        check({dc_strobe, dev_strobe, clint_en} == 0, "rst_strobes", 64'({dc_strobe, dev_strobe, clint_en}), 0);
        rst = 1'b0;
        idle(2);

        // D-cache read, ready 3 cycles after the strobe
        txn(32'h8000_0040, 1'b0, 4'hF, 32'h0, 3, 32'hDEADBEEF, t0);
        check(last_ready_cyc - t0 == 5, "t1_latency", 64'(last_ready_cyc - t0), 5);
        check(last_rdata == 32'hDEADBEEF, "t1_rdata", 64'(last_rdata), 64'hDEADBEEF);
        check(last_err == 0, "t1_err", 64'(last_err), 0);
        idle(1);

        // Device 2 write, ready while the strobe is still up
        dev_strobe_cycles = 0;
        txn(32'hC200_0010, 1'b1, 4'b0011, 32'h1234, 0, 32'h0, t0);
        check(last_dev_strobe == 4'b0100, "t2_dev_strobe", 64'(last_dev_strobe), 4);
        check(last_dev_rw == 1'b1, "t2_dev_rw", 64'(last_dev_rw), 1);
        check(last_t_be == 4'b0011, "t2_t_be", 64'(last_t_be), 3);
        check(dev_strobe_cycles == 1, "t2_strobe_once", 64'(dev_strobe_cycles), 1);
        check(last_ready_cyc - t0 == 2, "t2_latency", 64'(last_ready_cyc - t0), 2);
        check(last_err == 0, "t2_err", 64'(last_err), 0);
        idle(1);

        // CLINT read
        txn(32'hF000_0008, 1'b0, 4'hF, 32'h0, 0, 32'h55, t0);
        check(last_ready_cyc - t0 == 2, "t3_latency", 64'(last_ready_cyc - t0), 2);
        check(last_rdata == 32'h55, "t3_rdata", 64'(last_rdata), 64'h55);

        // Unmapped: hole and out-of-range device
        txn(32'h1000_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, t0);
        check(last_ready_cyc - t0 == 1, "t4a_latency", 64'(last_ready_cyc - t0), 1);
        check(last_err == 1, "t4a_err", 64'(last_err), 1);
        txn(32'hC500_0000, 1'b0, 4'hF, 32'h0, 0, 32'h0, t0);
        check(last_ready_cyc - t0 == 1, "t4b_latency", 64'(last_ready_cyc - t0), 1);
        check(last_err == 1, "t4b_err", 64'(last_err), 1);

        // Device 1 never answers, then a late ready in IDLE, then a normal request
        txn(32'hC100_0000, 1'b0, 4'hF, 32'h0, 1000, 32'h77, t0);
        check(last_ready_cyc - t0 == TO + 2, "t5_latency", 64'(last_ready_cyc - t0), TO + 2);
        check(last_err == 1, "t5_err", 64'(last_err), 1);
        check(last_rdata == 0, "t5_rdata", 64'(last_rdata), 0);
        dev_ready = 4'b0010;
        @(negedge clk);
        @(negedge clk);
        dev_ready = 4'b0000;
        txn(32'hC100_0004, 1'b0, 4'hF, 32'h0, 2, 32'hA5A5, t0);
        check(last_ready_cyc - t0 == 4, "t5_next_latency", 64'(last_ready_cyc - t0), 4);
        check(last_rdata == 32'hA5A5 && last_err == 0, "t5_next_rdata", 64'(last_rdata), 64'hA5A5);

        // Reset while waiting on the D-cache
        ew.issue_cyc = cyc + 1; ew.done_cyc = cyc + 1000; ew.tgt = 0; ew.idx = 0;
        ew.rw = 1'b0; ew.addr = 32'h8000_0100; ew.be = 4'hF; ew.wd = 32'h0;
        ew.rdata = 32'h0; ew.err = 1'b0;
        dc_ready = 0; dev_ready = 0;
        p_strobe = 1; p_addr = 32'h8000_0100; p_rw = 0; p_byte_enable = 4'hF; p_wdata = 0;
        q.push_back(ew);
        @(negedge clk);
        p_strobe = 0;
        @(negedge clk);
        @(negedge clk);
        #2;
        q.delete();
        rst = 1'b1;
        #1;
        check(p_ready == 0, "t6_p_ready", 64'(p_ready), 0);
        check({dc_strobe, dev_strobe, clint_en} == 0, "t6_strobes", 64'({dc_strobe, dev_strobe, clint_en}), 0);
        check(t_addr == 0, "t6_t_addr", 64'(t_addr), 0);
        check(p_rdata == 0 && p_err == 0, "t6_resp", 64'({p_rdata, p_err}), 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        txn(32'h8000_0200, 1'b0, 4'hF, 32'h0, 1, 32'h0BADF00D, t0);
        check(last_ready_cyc - t0 == 3, "t6_after_latency", 64'(last_ready_cyc - t0), 3);
        check(last_rdata == 32'h0BADF00D, "t6_after_rdata", 64'(last_rdata), 64'h0BADF00D);

        // Randomised mix across all regions, delays straddling the timeout
        for (int i = 0; i < 80; i++) begin
            cat = $urandom_range(0, 5);
            a   = $urandom;
            rw  = 1'($urandom);
            d   = $urandom_range(0, 20);
            case (cat)
                0, 1: a[31:28] = 4'($urandom_range(8, 11));
                2:    a[31:24] = {4'hC, 4'($urandom_range(0, ND - 1))};
                3:    a[31:24] = {4'hC, 4'($urandom_range(ND, 15))};
                4: begin
                    a[31:28] = 4'hF;
                    rw = 1'b0;
                end
                default: begin
                    v = $urandom_range(0, 9);
                    a[31:28] = (v < 8) ? 4'(v) : ((v == 8) ? 4'hD : 4'hE);
                end
            endcase
            txn(a, rw, 4'($urandom), $urandom, d, $urandom, t0);
            idle($urandom_range(0, 3));
        end

        idle(3);
        check(q.size() == 0, "model_drained", 64'(q.size()), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
